// File: rtl/autosym_pkg.sv
// Shared types and helpers for the autosymmetry scanner.
//   state_e       : scanner FSM states
//   tt_xor_shift  : g[x] = tt[x ^ alpha] over a max-width truth table
//   log2_onehot   : index of the set bit of a power-of-two count
package autosym_pkg;

  localparam int N_IN_MAX = 6;
  localparam int TT_MAX   = 1 << N_IN_MAX;
  localparam int CNT_MAX_W = N_IN_MAX + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  // Narrower tables are zero-extended by the caller; x ^ alpha stays below
  // TT_W when both operands do, so the low TT_W bits of the result are exact.
  function automatic logic [TT_MAX-1:0] tt_xor_shift(input logic [TT_MAX-1:0]   tt,
                                                     input logic [N_IN_MAX-1:0] alpha);
    logic [TT_MAX-1:0] g;
    g = '0;
    for (int x = 0; x < TT_MAX; x++) g[x] = tt[N_IN_MAX'(x) ^ alpha];
    return g;
  endfunction

  function automatic logic [2:0] log2_onehot(input logic [CNT_MAX_W-1:0] count);
    logic [2:0] k;
    k = '0;
    for (int i = 0; i < CNT_MAX_W; i++) if (count[i]) k = 3'(i);
    return k;
  endfunction

endpackage

// File: rtl/autosym_xor_permute.sv
// Combinational XOR-index permutation: g[x] = tt[x ^ alpha] for all x.
//   tt    : input truth table (TT_W bits)
//   alpha : XOR offset applied to every minterm index
//   g     : permuted truth table
module autosym_xor_permute
  import autosym_pkg::*;
#(
  parameter  int N_IN = 6,
  localparam int TT_W = 2**N_IN
) (
  input  logic [TT_W-1:0] tt,
  input  logic [N_IN-1:0] alpha,
  output logic [TT_W-1:0] g
);

  logic [TT_MAX-1:0] g_full;

  assign g_full = tt_xor_shift(TT_MAX'(tt), N_IN_MAX'(alpha));
  assign g      = g_full[TT_W-1:0];

endmodule

// File: rtl/autosym_space_scanner.sv
// Sequential autosymmetry-space analyzer. Captures a truth table, then tests
// one candidate shift alpha per cycle (TT_W cycles) and reports
// L_f = {a : f(x^a) = f(x) for all x} as a mask plus its dimension.
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_ready/in_tt       : truth-table input handshake
//   out_valid/out_ready           : result handshake
//   out_lmask                     : bit a set iff a in L_f
//   out_dim                       : log2 |L_f|
//   out_const                     : f is constant (|L_f| == TT_W)
module autosym_space_scanner
  import autosym_pkg::*;
#(
  parameter  int N_IN = 6,
  localparam int TT_W = 2**N_IN,
  localparam int CW   = $clog2(TT_W) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TT_W-1:0] in_tt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TT_W-1:0] out_lmask,
  output logic [2:0]      out_dim,
  output logic            out_const
);

  state_e          state_q, state_d;
  logic [TT_W-1:0] tt_q;
  logic [TT_W-1:0] mask_q;
  logic [N_IN-1:0] alpha;
  logic [CW-1:0]   cnt;
  logic [TT_W-1:0] g;
  logic            match;
  logic            last_alpha;

  autosym_xor_permute #(.N_IN(N_IN)) u_perm (
    .tt    (tt_q),
    .alpha (alpha),
    .g     (g)
  );

  assign match      = (g == tt_q);
  assign last_alpha = &alpha;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SCAN;
      end
      SCAN: if (last_alpha) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter is cleared on capture so an aborted scan never leaks into the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q   <= '0;
      mask_q <= '0;
      alpha  <= '0;
      cnt    <= '0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        tt_q   <= in_tt;
        mask_q <= '0;
        alpha  <= '0;
        cnt    <= '0;
      end
      if (state_q == SCAN) begin
        mask_q[alpha] <= match;
        if (match)       cnt   <= cnt + 1'b1;
        if (!last_alpha) alpha <= alpha + 1'b1;
      end
    end
  end

  // L_f is a linear subspace, so the member count is a power of two.
  assign out_lmask = mask_q;
  assign out_dim   = log2_onehot(CNT_MAX_W'(cnt));
  assign out_const = (cnt == CW'(TT_W));

  a_cnt_pow2: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == DONE) |-> $onehot(cnt));
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= CW'(TT_W));
  a_zero_member: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == DONE) |-> mask_q[0]);

endmodule

// File: tb/tb_autosym_space_scanner.sv
module tb_autosym_space_scanner;

  localparam int TT_W = 64;
  localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PARITY = 64'h6996_9669_9669_6996;
  localparam logic [63:0] X0     = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] X2     = 64'hF0F0_F0F0_F0F0_F0F0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_tt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_lmask;
  logic [2:0]  out_dim;
  logic        out_const;

  autosym_space_scanner #(.N_IN(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tt     (in_tt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lmask (out_lmask),
    .out_dim   (out_dim),
    .out_const (out_const)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model straight from the definition of L_f.
  function automatic logic [63:0] model_lmask(input logic [63:0] t);
    logic [63:0] m;
    m = '0;
    for (int a = 0; a < TT_W; a++) begin
      bit ok = 1'b1;
      for (int x = 0; x < TT_W; x++) if (t[x ^ a] != t[x]) ok = 1'b0;
      m[a] = ok;
    end
    return m;
  endfunction

  function automatic int model_dim(input logic [63:0] t);
    int pc, k;
    pc = $countones(model_lmask(t));
    k = 0;
    while ((1 << k) < pc) k++;
    return k;
  endfunction

  function automatic bit model_const(input logic [63:0] t);
    return (t == '0) || (t == ALL1);
  endfunction

  // Transaction-level model: idle/busy plus cycles since acceptance.
  bit          m_busy = 1'b0;
  int          m_cyc  = 0;
  logic [63:0] m_tt   = '0;
  bit          exp_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
    end else begin
      exp_v = m_busy && (m_cyc >= TT_W + 1);
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, exp_v);
      if (exp_v) begin
        chk("m_lmask", out_lmask, model_lmask(m_tt));
        chk("m_dim", out_dim, model_dim(m_tt));
        chk("m_const", out_const, model_const(m_tt));
      end
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1;
          m_cyc  = 1;
          m_tt   = in_tt;
        end
      end else if (exp_v && out_ready) m_busy = 1'b0;
      else m_cyc++;
    end
  end

  task automatic send(input logic [63:0] t);
    bit rdy;
    int guard;
    guard = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_tt    = t;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      guard++;
    end while (!rdy && guard < 200);
    #1 in_valid = 1'b0;
    if (!rdy) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 300);
  endtask

  task automatic drain();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic run(input string nm, input logic [63:0] t, input logic [63:0] em,
                     input int ed, input bit ec);
    int lat;
    send(t);
    wait_result(lat);
    chk({nm, "_latency"}, lat, 65);
    chk({nm, "_lmask"}, out_lmask, em);
    chk({nm, "_dim"}, out_dim, ed);
    chk({nm, "_const"}, out_const, ec);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    #22;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_lmask", out_lmask, 0);
    chk("reset_dim", out_dim, 0);
    chk("reset_const", out_const, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run("zero",   64'h0,  ALL1, 6, 1'b1);
    run("ones",   ALL1,   ALL1, 6, 1'b1);
    run("parity", PARITY, 64'h9669_6996_6996_9669, 5, 1'b0);
    run("x0",     X0,     64'h5555_5555_5555_5555, 5, 1'b0);
    run("single", 64'h1,  64'h1, 0, 1'b0);

    // Backpressure: hold result while a second table is offered.
    send(X0);
    wait_result(lat);
    chk("bp_latency", lat, 65);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_tt    = X2;
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_lmask", out_lmask, 64'h5555_5555_5555_5555);
      chk("bp_dim", out_dim, 5);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("bp_ready_after", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_result(lat);
    chk("bp2_latency", lat, 65);
    chk("bp2_lmask", out_lmask, 64'h0F0F_0F0F_0F0F_0F0F);
    chk("bp2_dim", out_dim, 5);
    chk("bp2_const", out_const, 0);
    drain();

    // Abort mid-scan at alpha = 30.
    send(PARITY);
    repeat (30) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_lmask", out_lmask, 0);
    chk("abort_dim", out_dim, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run("after_abort", X2, 64'h0F0F_0F0F_0F0F_0F0F, 5, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/autosym_space_scanner.md
Name: autosym_space_scanner

Overview:
- Sequential analyzer for 6-input single-output Boolean functions, as produced by the optimized benchmark netlists.
- Accepts the function as a 2^N_IN-bit truth table and computes its autosymmetry space L_f = {a : f(x XOR a) = f(x) for all x}.
- Returns L_f as a membership mask plus its dimension k = log2|L_f|.
- Sits on the consumer side of the netlist flow: the evaluation harness writes truth tables in, and the reduction tooling reads L_f out.

Parameters:
- N_IN, 6, number of function inputs; supported range 2..6.
- TT_W, 2**N_IN, truth-table width (derived, not overridable).
- CW, $clog2(TT_W)+1, width of the member counter.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  truth table offered.
- in_ready  output  1  block can accept a truth table.
- in_tt  input  TT_W  bit i = f(x) for minterm x = i (x0 is LSB).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_lmask  output  TT_W  bit a = 1 iff a is in L_f.
- out_dim  output  3  k = log2 of popcount(out_lmask), range 0..N_IN.
- out_const  output  1  f is constant, equivalently out_dim == N_IN.

Behaviour:
- Reset (async assert, sync deassert in the caller's domain) puts the block in IDLE and clears all outputs: in_ready=1, out_valid=0, out_lmask=0, out_dim=0, out_const=0.
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - in_ready=1.
  - An in_valid&in_ready handshake captures in_tt into tt_q, clears mask_q, sets alpha=0 and enters SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle, form g[x] = tt_q[x XOR alpha] for all x in parallel. Set mask_q[alpha] = (g == tt_q) and increment the counter on a match.
  - alpha advances by 1 each cycle. After alpha = TT_W-1 the FSM goes to DONE; alpha does not wrap.
  - Exactly TT_W cycles are spent in SCAN. alpha=0 always matches.
- DONE:
  - out_valid=1; out_lmask=mask_q.
  - out_dim = index of the single set bit of the counter. The counter is always a power of 2 because L_f is a linear subspace.
  - out_const = (count == TT_W).
  - Outputs hold stable while out_valid & ~out_ready.
  - On the out_valid&out_ready handshake: return to IDLE, drop out_valid and keep the last result on out_lmask/out_dim (don't-care for checking).
- Latency: the input handshake is at cycle 0; out_valid is first high at cycle TT_W+1 (65 for N_IN=6).
- Throughput: one function per TT_W+2 cycles when out_ready is tied high.
- in_valid during SCAN/DONE is ignored; in_tt is not sampled and the source must hold it.
- rst_n asserted mid-SCAN or mid-DONE aborts immediately. No partial result is ever emitted, and the next accepted table starts from a clean state.
- Internal consistency requirements:
  - The counter never exceeds TT_W; width CW prevents overflow at TT_W.
  - The mask is closed under XOR.
  - A non-power-of-2 count is a design error and is flagged by an assertion.

Decomposition:
- Package autosym_pkg holds:
  - state enum {IDLE, SCAN, DONE};
  - functions tt_xor_shift(tt, alpha) and log2_onehot(count);
  - constant N_IN_MAX = 6.
- One natural sub-module: autosym_xor_permute, a purely combinational TT_W-wide XOR-index permutation network (tt, alpha -> g). It is reused by the future reduced-function (f_k) extractor.

Test Plan:
- in_tt = 64'h0 -> after 65 cycles out_lmask = 64'hFFFF_FFFF_FFFF_FFFF, out_dim = 6, out_const = 1; same result for 64'hFFFF_FFFF_FFFF_FFFF.
- in_tt = 64'h6996_9669_9669_6996 (parity of x0..x5) -> out_lmask = 64'h9669_6996_6996_9669 (even-weight alphas), out_dim = 5, out_const = 0.
- in_tt = 64'hAAAA_AAAA_AAAA_AAAA (f = x0) -> out_lmask = 64'h5555_5555_5555_5555, out_dim = 5.
- in_tt = 64'h0000_0000_0000_0001 (single minterm) -> out_lmask = 64'h1, out_dim = 0.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> outputs stable, in_ready = 0 and a second in_valid is not accepted. After the handshake, in_ready = 1 in the next cycle and the second table is processed correctly.
- Reset mid-operation: assert rst_n = 0 at alpha = 30 -> out_valid = 0 and in_ready = 1 immediately. A subsequent table of 64'hF0F0_F0F0_F0F0_F0F0 (f = x2) -> out_lmask = 64'h0F0F_0F0F_0F0F_0F0F, out_dim = 5.
